// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: run/stop/clear sequencing, 1 kHz prescaler, cs/sec/min/hour
// counter chain and lap-hold snapshot feeding the FND display formatter.
module stopwatch_cu #(
   parameter int TICK_DIV = 10,
   parameter int CS_MAX   = 100,
   parameter int SEC_MAX  = 60,
   parameter int MIN_MAX  = 60,
   parameter int HOUR_MAX = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick_1khz,
   input  logic       i_btn_run,
   input  logic       i_btn_clear,
   input  logic       i_btn_lap,
   output logic [6:0] o_cs,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic       o_running,
   output logic       o_lap_hold
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CLEAR} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [6:0]      cs_q, cs_d, snap_cs_q, snap_cs_d;
   logic [5:0]      sec_q, sec_d, snap_sec_q, snap_sec_d;
   logic [5:0]      min_q, min_d, snap_min_q, snap_min_d;
   logic [4:0]      hour_q, hour_d, snap_hour_q, snap_hour_d;
   logic            hold_q, hold_d;
   logic            cs_inc;

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      cs_d        = cs_q;
      sec_d       = sec_q;
      min_d       = min_q;
      hour_d      = hour_q;
      snap_cs_d   = snap_cs_q;
      snap_sec_d  = snap_sec_q;
      snap_min_d  = snap_min_q;
      snap_hour_d = snap_hour_q;
      hold_d      = hold_q;
      cs_inc      = 1'b0;

      unique case (state_q)
         ST_STOP: begin
            if (i_btn_lap && hold_q) hold_d = 1'b0;
            if (i_btn_clear)         state_d = ST_CLEAR;
            else if (i_btn_run)      state_d = ST_RUN;
         end
         ST_RUN: begin
            if (i_tick_1khz) begin
               if (presc_q == PW'(TICK_DIV - 1)) begin
                  presc_d = '0;
                  cs_inc  = 1'b1;
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            // Snapshot takes the pre-edge live values, even when a carry lands on this edge
            if (i_btn_lap) begin
               if (hold_q) begin
                  hold_d = 1'b0;
               end else begin
                  hold_d      = 1'b1;
                  snap_cs_d   = cs_q;
                  snap_sec_d  = sec_q;
                  snap_min_d  = min_q;
                  snap_hour_d = hour_q;
               end
            end
            if (i_btn_run) state_d = ST_STOP;
         end
         ST_CLEAR: begin
            presc_d     = '0;
            cs_d        = '0;
            sec_d       = '0;
            min_d       = '0;
            hour_d      = '0;
            snap_cs_d   = '0;
            snap_sec_d  = '0;
            snap_min_d  = '0;
            snap_hour_d = '0;
            hold_d      = 1'b0;
            state_d     = ST_STOP;
         end
         default: state_d = ST_STOP;
      endcase

      if (cs_inc) begin
         if (cs_q == 7'(CS_MAX - 1)) begin
            cs_d = '0;
            if (sec_q == 6'(SEC_MAX - 1)) begin
               sec_d = '0;
               if (min_q == 6'(MIN_MAX - 1)) begin
                  min_d  = '0;
                  hour_d = (hour_q == 5'(HOUR_MAX - 1)) ? '0 : hour_q + 5'd1;
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end else begin
            cs_d = cs_q + 7'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_STOP;
         presc_q     <= '0;
         cs_q        <= '0;
         sec_q       <= '0;
         min_q       <= '0;
         hour_q      <= '0;
         snap_cs_q   <= '0;
         snap_sec_q  <= '0;
         snap_min_q  <= '0;
         snap_hour_q <= '0;
         hold_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         cs_q        <= cs_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hour_q      <= hour_d;
         snap_cs_q   <= snap_cs_d;
         snap_sec_q  <= snap_sec_d;
         snap_min_q  <= snap_min_d;
         snap_hour_q <= snap_hour_d;
         hold_q      <= hold_d;
      end
   end

   assign o_cs       = hold_q ? snap_cs_q   : cs_q;
   assign o_sec      = hold_q ? snap_sec_q  : sec_q;
   assign o_min      = hold_q ? snap_min_q  : min_q;
   assign o_hour     = hold_q ? snap_hour_q : hour_q;
   assign o_running  = (state_q == ST_RUN);
   assign o_lap_hold = hold_q;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Bench for stopwatch_cu: a default-sized and a tiny-modulus instance share stimulus and
// are checked every cycle against an elapsed-tick reference model through a scoreboard.
module tb_stopwatch_cu;

   localparam int BT = 10, BC = 100, BS = 60, BM = 60, BH = 24;
   localparam int ST = 2,  SC = 3,   SS = 3,  SM = 2,  SH = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tick = 1'b0, b_run = 1'b0, b_clr = 1'b0, b_lap = 1'b0;

   logic [6:0] bg_cs, sm_cs;
   logic [5:0] bg_sec, sm_sec, bg_min, sm_min;
   logic [4:0] bg_hour, sm_hour;
   logic       bg_running, sm_running, bg_hold, sm_hold;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stopwatch_cu u_big (
      .clk(clk), .rst(rst), .i_tick_1khz(tick), .i_btn_run(b_run),
      .i_btn_clear(b_clr), .i_btn_lap(b_lap),
      .o_cs(bg_cs), .o_sec(bg_sec), .o_min(bg_min), .o_hour(bg_hour),
      .o_running(bg_running), .o_lap_hold(bg_hold)
   );

   stopwatch_cu #(.TICK_DIV(ST), .CS_MAX(SC), .SEC_MAX(SS), .MIN_MAX(SM), .HOUR_MAX(SH)) u_small (
      .clk(clk), .rst(rst), .i_tick_1khz(tick), .i_btn_run(b_run),
      .i_btn_clear(b_clr), .i_btn_lap(b_lap),
      .o_cs(sm_cs), .o_sec(sm_sec), .o_min(sm_min), .o_hour(sm_hour),
      .o_running(sm_running), .o_lap_hold(sm_hold)
   );

   typedef struct packed {
      logic [6:0] cs;
      logic [5:0] sec;
      logic [5:0] min;
      logic [4:0] hour;
   } tv_t;

   // Model state: elapsed 1 kHz ticks since the last clear, plus mode flags
   typedef struct {
      longint ticks;
      bit     running;
      bit     clearing;
      bit     hold;
      tv_t    snap;
   } mdl_t;

   typedef struct {
      tv_t bt; bit brun; bit bhold;
      tv_t st; bit srun; bit shold;
   } exp_t;

   exp_t q[$];
   mdl_t mb, ms;

   function automatic tv_t disp(longint ticks, int td, int cm, int sm, int mm);
      tv_t v;
      longint c;
      c      = ticks / td;
      v.cs   = 7'(c % cm);  c = c / cm;
      v.sec  = 6'(c % sm);  c = c / sm;
      v.min  = 6'(c % mm);  c = c / mm;
      v.hour = 5'(c);
      return v;
   endfunction

   function automatic mdl_t mreset();
      mdl_t m;
      m.ticks = 0; m.running = 0; m.clearing = 0; m.hold = 0; m.snap = '0;
      return m;
   endfunction

   function automatic mdl_t mstep(mdl_t m, bit t, bit r, bit c, bit l,
                                  int td, int cm, int sm, int mm, int hm);
      mdl_t   n = m;
      longint period = longint'(td) * cm * sm * mm * hm;
      if (m.clearing) begin
         n = mreset();
      end else if (m.running) begin
         if (t) n.ticks = (m.ticks + 1) % period;
         if (l) begin
            if (m.hold) n.hold = 0;
            else begin
               n.hold = 1;
               n.snap = disp(m.ticks, td, cm, sm, mm);
            end
         end
         if (r) n.running = 0;
      end else begin
         if (l && m.hold) n.hold = 0;
         if (c)      n.clearing = 1;
         else if (r) n.running  = 1;
      end
      return n;
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      e.bt    = mb.hold ? mb.snap : disp(mb.ticks, BT, BC, BS, BM);
      e.brun  = mb.running;
      e.bhold = mb.hold;
      e.st    = ms.hold ? ms.snap : disp(ms.ticks, ST, SC, SS, SM);
      e.srun  = ms.running;
      e.shold = ms.hold;
      return e;
   endfunction

   task automatic chk(string name, int got, int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic compare_all(exp_t e);
      chk("big.cs",      bg_cs,      e.bt.cs);
      chk("big.sec",     bg_sec,     e.bt.sec);
      chk("big.min",     bg_min,     e.bt.min);
      chk("big.hour",    bg_hour,    e.bt.hour);
      chk("big.running", bg_running, e.brun);
      chk("big.hold",    bg_hold,    e.bhold);
      chk("small.cs",    sm_cs,      e.st.cs);
      chk("small.sec",   sm_sec,     e.st.sec);
      chk("small.min",   sm_min,     e.st.min);
      chk("small.hour",  sm_hour,    e.st.hour);
      chk("small.run",   sm_running, e.srun);
      chk("small.hold",  sm_hold,    e.shold);
   endtask

   // Monitor: compares the expectation for the edge just taken, 2 ns after it
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            compare_all(e);
         end
      end
   end

   // Called at posedge+1: drive inputs, model the coming edge, queue its expectation
   task automatic step(bit t, bit r, bit c, bit l);
      tick = t; b_run = r; b_clr = c; b_lap = l;
      mb = mstep(mb, t, r, c, l, BT, BC, BS, BM, BH);
      ms = mstep(ms, t, r, c, l, ST, SC, SS, SM, SH);
      @(posedge clk);
      q.push_back(expect_now());
      #1;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Reset asserted mid-cycle; outputs must clear without a clock edge
   task automatic async_reset();
      tick = 0; b_run = 0; b_clr = 0; b_lap = 0;
      #2;
      rst = 1'b0;
      #1;
      mb = mreset();
      ms = mreset();
      compare_all(expect_now());
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      mb = mreset();
      ms = mreset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      step(0, 1, 0, 0);
      ticks(10);
      ticks(990);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      step(0, 1, 0, 0);
      ticks(25);
      step(0, 1, 0, 0);
      ticks(20);
      step(0, 1, 0, 0);
      ticks(5);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      step(0, 1, 0, 0);
      ticks(3000);
      step(0, 0, 0, 1);
      ticks(2000);
      step(0, 0, 0, 1);
      ticks(7);

      step(0, 0, 1, 0);
      ticks(4);
      step(0, 1, 0, 1);
      step(0, 0, 0, 0);
      step(0, 1, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      step(0, 1, 0, 0);
      ticks(9);
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);

      step(0, 1, 0, 0);
      ticks(37);
      async_reset();
      step(0, 1, 0, 0);
      ticks(10);
      step(0, 1, 0, 0);

      for (int i = 0; i < 20000; i++) begin
         step(($urandom % 2) == 0, ($urandom % 40) == 0,
              ($urandom % 30) == 0, ($urandom % 25) == 0);
         if (($urandom % 3000) == 0) async_reset();
      end

      step(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #3;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d required=0", q.size());
      end
      if (total == 0) begin
         bad++;
         $display("FAIL no_checks total=0 required>0");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
